adder_8b: RTL and testbench
===========================

// Module: adder_8b
// PURPOSE
//   Registered two-operand unsigned adder. Each clock cycle it samples a and b
//   and presents their sum on c one cycle later.
//   Small arithmetic leaf in the datapath; also the lab's reference for
//   clocked-output timing and synchronous reset.
// PARAMETERS
//   WIDTH  8  operand and result width in bits; must be >= 1
// PORTS
//   clk    in   1      rising-edge clock; the only clock
//   reset  in   1      synchronous, active-high reset
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   c      out  WIDTH  registered sum, unsigned
// BEHAVIOUR
//   - Clocking: one clock domain. reset is synchronous and active-high; it is
//     sampled only on the rising edge of clk.
//   - Reset: reset=1 at a rising edge -> c=0 from that edge on. reset
//     overrides the a/b sample taken in the same cycle.
//   - Normal operation: at each rising edge with reset=0, c <= a + b.
//   - Latency: exactly 1 cycle. No handshake; a new result every cycle.
//   - c is driven directly from a flop, with no combinational path from a or b.
//   - Arithmetic (default build): sum is computed at WIDTH+1 bits.
//     c = sum[WIDTH-1:0], i.e. modulo 2^WIDTH wrap-around. The carry-out is
//     discarded.
//   - Boundaries: 0+0 -> 0; (2^W-1)+1 -> 0; (2^W-1)+(2^W-1) -> 2^W-2.
//   - Reset mid-operation: the result already in flight is discarded.
//     c=0 on the edge after reset is asserted. The first real sum appears one
//     edge after reset deasserts.
//   - Before the first reset, c is undefined (X in simulation). No initial
//     value is relied on.
//   - X or Z on a or b propagates to c; no masking.
// CONFIGURATION
//   Macro ADDER_SATURATE_EN:
//   - Defined: unsigned saturation. If the WIDTH+1-bit sum exceeds 2^W-1,
//     c <= all-ones; otherwise c <= sum. Reset and latency are unchanged.
//   - Undefined: modulo wrap as described above (default).
//   Port list is identical in both builds.
// STRUCTURE
//   - adder_pkg holds:
//     - ADDER_WIDTH_DEFAULT = 8
//     - function sat_or_wrap(sum, sat) shared by RTL and bench model
//   - One sub-module, adder_core: purely combinational, explicit ripple-carry
//     chain of WIDTH full-adder cells (generate loop).
//     Outputs sum[WIDTH-1:0] and cout.
//   - Top level adds the saturation/wrap select and the output register with
//     synchronous reset.
// TESTING
//   Bench: free-running clk, period 10. Each check is made 1 cycle after the
//   stimulus is applied.
//   1. Reset: reset=1 for one edge with a=0, b=0 -> c=0.
//      Hold reset=1 with a=4, b=7 -> c stays 0.
//   2. Basic sums: reset=0, a=4, b=7 -> c=11 after the next edge.
//      Then a=8, b=17 -> c=25 one edge later.
//   3. Back-to-back: change a and b every cycle (1+2, 3+4, 5+6) -> c gives
//      3, 7, 11 on consecutive edges, with no bubbles.
//   4. Overflow: a=200, b=100 -> c=44 (default build) or c=255 with
//      ADDER_SATURATE_EN.
//      a=255, b=1 -> c=0 (default) or 255 (saturating).
//   5. Mid-stream reset: a=10, b=20, and reset=1 at that same edge -> c=0.
//      Release reset -> c=30 one edge later.
//   6. Random: 1000 random a/b pairs compared each cycle against
//      sat_or_wrap(a+b) from the previous cycle; zero mismatches required.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and the saturate/wrap result selector for the registered adder.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 8;
  localparam int unsigned ADDER_MAX_WIDTH     = 64;

  // sum holds the full width+1-bit addition zero-extended to ADDER_MAX_WIDTH+1 bits.
  // The result is valid in the low 'width' bits; upper bits are always zero.
  function automatic logic [ADDER_MAX_WIDTH-1:0] sat_or_wrap(
    input logic [ADDER_MAX_WIDTH:0] sum,
    input int unsigned              width,
    input logic                     sat
  );
    logic [ADDER_MAX_WIDTH-1:0] mask;
    logic                       over;
    mask = '1 >> (ADDER_MAX_WIDTH - width);
    over = (sum >> width) != '0;
    if (sat && over) return mask;
    return sum[ADDER_MAX_WIDTH-1:0] & mask;
  endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational ripple-carry adder built from WIDTH full-adder cells.
module adder_core
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_8b.sv
// Registered unsigned adder, one-cycle latency, synchronous active-high reset.
// Define ADDER_SATURATE_EN to clamp overflowing sums to all-ones instead of wrapping.
module adder_8b
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

`ifdef ADDER_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [WIDTH-1:0]         sum_core;
  logic                     cout_core;
  logic [ADDER_MAX_WIDTH:0] sum_ext;
  logic [WIDTH-1:0]         c_d;
  logic [WIDTH-1:0]         c_q;

  adder_core #(.WIDTH(WIDTH)) u_core (
    .a    (a),
    .b    (b),
    .sum  (sum_core),
    .cout (cout_core)
  );

  always_comb begin
    sum_ext          = '0;
    sum_ext[WIDTH:0] = {cout_core, sum_core};
    c_d              = WIDTH'(sat_or_wrap(sum_ext, WIDTH, SAT_EN));
  end

  always_ff @(posedge clk) begin
    if (reset) c_q <= '0;
    else       c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: tb/tb_adder_8b.sv
// Scoreboard bench for adder_8b: driver queues expected results, monitor checks each cycle.
module tb_adder_8b;
  import adder_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

`ifdef ADDER_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] c;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  adder_8b dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the matching result is due after the next rising edge.
  task automatic drive(input logic r, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    reset = r;
    a     = va;
    b     = vb;
    e.name = name;
    e.exp  = exp;
    q.push_back(e);
  endtask

  function automatic logic [7:0] model(input logic [7:0] va, input logic [7:0] vb);
    logic [ADDER_MAX_WIDTH:0] s;
    s = (ADDER_MAX_WIDTH+1)'(va) + (ADDER_MAX_WIDTH+1)'(vb);
    return 8'(sat_or_wrap(s, 8, SAT));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (c !== e.exp) begin
          n_fail++;
          $display("FAIL %s: c=%0d (0x%h) expected %0d", e.name, c, c, e.exp);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0] ra, rb;
    int         drain;

    drive(1'b1, 8'd0, 8'd0, 8'd0, "reset_zero");
    drive(1'b1, 8'd4, 8'd7, 8'd0, "reset_hold");

    drive(1'b0, 8'd4,  8'd7,  8'd11, "sum_4_7");
    drive(1'b0, 8'd8,  8'd17, 8'd25, "sum_8_17");

    drive(1'b0, 8'd1, 8'd2, 8'd3,  "b2b_1_2");
    drive(1'b0, 8'd3, 8'd4, 8'd7,  "b2b_3_4");
    drive(1'b0, 8'd5, 8'd6, 8'd11, "b2b_5_6");

    drive(1'b0, 8'd200, 8'd100, SAT ? 8'd255 : 8'd44,  "ovf_200_100");
    drive(1'b0, 8'd255, 8'd1,   SAT ? 8'd255 : 8'd0,   "ovf_255_1");
    drive(1'b0, 8'd255, 8'd255, SAT ? 8'd255 : 8'd254, "ovf_255_255");
    drive(1'b0, 8'd0,   8'd0,   8'd0,                  "zero_0_0");
    drive(1'b0, 8'd128, 8'd127, 8'd255,                "max_no_ovf");

    drive(1'b1, 8'd10, 8'd20, 8'd0,  "midreset");
    drive(1'b0, 8'd10, 8'd20, 8'd30, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive(1'b0, ra, rb, model(ra, rb), "random");
    end

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
